stream_serializer: RTL

- Parametrised parallel-to-serial converter and next generation of the team's fixed 16x32 serializer.
- Accepts a frame of LANES words of DATA_W bits through a valid/ready handshake.
- Emits the frame one word per beat on a valid/ready output stream, with a last-beat flag, runtime frame length and selectable lane order.
- Sits between wide datapath stages (e.g. accumulator arrays) and narrow streaming consumers.

---
 rtl/ser_pkg.sv | 10 +
 rtl/ser_frame_buf.sv | 43 ++++
 rtl/stream_serializer.sv | 116 +++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// ser_pkg: shared state type, default geometry and frame-length saturation for stream_serializer.
package ser_pkg;
    typedef enum logic {IDLE, SHIFT} ser_state_e;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LANES  = 16;
    // A zero or over-long request emits the whole frame; there is no wrap past the top lane.
    function automatic int eff_len(input int len, input int lanes);
        return (len == 0 || len > lanes) ? lanes : len;
    endfunction
endpackage

// File: rtl/ser_frame_buf.sv
// ser_frame_buf: frame register holding lane data and effective length, with load and sync clear.
module ser_frame_buf
    import ser_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int LEN_W  = $clog2(LANES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] d_data [LANES],
    input  logic        [LEN_W-1:0]  d_len,
    output logic signed [DATA_W-1:0] q_data [LANES],
    output logic        [LEN_W-1:0]  q_len
);
    logic signed [DATA_W-1:0] data_q [LANES];
    logic signed [DATA_W-1:0] data_d [LANES];
    logic [LEN_W-1:0] len_q, len_d;
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        if (clr) begin
            data_d = '{default: '0};
            len_d  = '0;
        end else if (load) begin
            data_d = d_data;
            len_d  = d_len;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '{default: '0};
            len_q  <= '0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
        end
    end
    assign q_data = data_q;
    assign q_len  = len_q;
endmodule

// File: rtl/stream_serializer.sv
// stream_serializer: frame-in, word-per-beat-out serializer with last flag, runtime length and lane order.
// Define SERIALIZER_PRELOAD_EN to add a shadow frame buffer for zero-bubble back-to-back frames.
module stream_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LANES     = DEF_LANES,
    parameter bit LSB_FIRST = 1'b1,
    parameter int LEN_W     = $clog2(LANES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] i_data [LANES],
    input  logic        [LEN_W-1:0]  i_len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_last,
    output logic                     busy
);
    localparam int IDX_W = $clog2(LANES);
    ser_state_e state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d, lane;
    logic signed [DATA_W-1:0] act_data [LANES];
    logic signed [DATA_W-1:0] ld_data [LANES];
    logic [LEN_W-1:0] act_len, ld_len, in_len;
    logic sh_full, accept, xfer, last, go_next, act_load_in, act_load_sh;
    assign in_len      = LEN_W'(eff_len(int'(i_len), LANES));
    assign accept      = in_valid && in_ready && !clr;
    assign xfer        = state_q == SHIFT && out_ready;
    assign last        = LEN_W'(k_q) + LEN_W'(1) == act_len;
    assign go_next     = xfer && last;
    // The active frame reloads from the input in IDLE or when a frame ends with no shadow waiting.
    assign act_load_in = accept && (state_q == IDLE || (go_next && !sh_full));
    assign act_load_sh = go_next && sh_full;
    ser_frame_buf #(.DATA_W(DATA_W), .LANES(LANES), .LEN_W(LEN_W)) u_act (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .load   (act_load_in || act_load_sh),
        .d_data (ld_data),
        .d_len  (ld_len),
        .q_data (act_data),
        .q_len  (act_len)
    );
`ifdef SERIALIZER_PRELOAD_EN
    logic signed [DATA_W-1:0] sh_data [LANES];
    logic [LEN_W-1:0] sh_len;
    logic sh_full_q, sh_full_d, sh_load;
    assign sh_load  = accept && state_q == SHIFT && !go_next;
    assign sh_full  = sh_full_q;
    assign in_ready = !sh_full_q;
    ser_frame_buf #(.DATA_W(DATA_W), .LANES(LANES), .LEN_W(LEN_W)) u_sh (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .load   (sh_load),
        .d_data (i_data),
        .d_len  (in_len),
        .q_data (sh_data),
        .q_len  (sh_len)
    );
    always_comb begin
        ld_data   = i_data;
        ld_len    = in_len;
        sh_full_d = clr ? 1'b0 : sh_load ? 1'b1 : act_load_sh ? 1'b0 : sh_full_q;
        if (act_load_sh) begin
            ld_data = sh_data;
            ld_len  = sh_len;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_full_q <= 1'b0;
        else        sh_full_q <= sh_full_d;
    end
`else
    assign sh_full  = 1'b0;
    assign in_ready = state_q == IDLE;
    assign ld_data  = i_data;
    assign ld_len   = in_len;
`endif
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (clr) begin
            state_d = IDLE;
            k_d     = '0;
        end else if (act_load_in || act_load_sh) begin
            state_d = SHIFT;
            k_d     = '0;
        end else if (go_next) begin
            state_d = IDLE;
            k_d     = '0;
        end else if (xfer) begin
            k_d = k_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end
    // Outputs decode flops only, so nothing on in_* reaches out_* combinationally.
    assign lane      = LSB_FIRST ? k_q : IDX_W'(LANES - 1) - k_q;
    assign o_data    = act_data[lane];
    assign out_valid = state_q == SHIFT;
    assign busy      = out_valid;
    assign o_last    = out_valid && last;
endmodule
